mem_arbiter: RTL and testbench

- Shares the single unified instruction/data memory of the multicycle core between two requesters:
  - the core's fetch/load/store port;
  - a debug/loader port used for program download and memory inspection.
- Sits between the core datapath (IorD address mux, MemWrite) and the memory.
- Memory transactions are serialized with a registered request/ready handshake.
- Core has fixed priority; a starvation counter guarantees debug progress.

---
 rtl/mem_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the unified instruction/data memory of the multicycle
// core between the core port (c_*) and a debug/loader port (d_*).
// - The core has fixed priority.
// - A starvation counter forces a debug grant after STARVE_LIMIT consecutive
//   core grants while d_req waits.
// - All m_* outputs are registered, so no combinational path runs from any
//   requester input to the memory.
// - A new grant can be issued in the same cycle that m_ready completes the
//   previous transaction (no bubble between transactions).
// Optional feature: define ARB_TIMEOUT_EN to abort a transaction that waits
// TIMEOUT cycles for m_ready. An aborted read returns 0xDEADBEEF and err
// pulses. Without the macro the arbiter waits indefinitely and err is tied to 0.
module mem_arbiter #(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned TIMEOUT      = 16
) (
   input  logic          clk,
   input  logic          reset,
   // core port
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   // debug/loader port
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   // memory side
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic          m_ready,
   input  logic [DW-1:0] m_rdata,
   // status
   output logic          busy,
   output logic          err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BUSY_C = 2'd1;
   localparam logic [1:0] S_BUSY_D = 2'd2;

   localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [DW-1:0] ABORT_DATA = DW'(32'hDEADBEEF);

   logic [1:0]    state_q, state_d;
   logic          m_req_q, m_req_d;
   logic          m_we_q, m_we_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [DW-1:0] m_wdata_q, m_wdata_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          c_rvalid_q, c_rvalid_d;
   logic [DW-1:0] c_rdata_q, c_rdata_d;
   logic          d_rvalid_q, d_rvalid_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;

   logic busy_st;
   logic complete;
   logic arb_point;
   logic d_wins;
   logic c_wins;
   logic abort;

   // Arbitration:
   // - an arbitration point is IDLE, or the BUSY cycle that completes;
   // - grants are suppressed while reset is high.
   assign busy_st   = (state_q == S_BUSY_C) || (state_q == S_BUSY_D);
   assign complete  = busy_st & m_ready;
   assign arb_point = ~reset & (~busy_st | m_ready);
   assign d_wins    = d_req & ((starve_q == STARVE_MAX) | ~c_req);
   assign c_wins    = c_req & ~d_wins;
   assign d_gnt     = arb_point & d_wins;
   assign c_gnt     = arb_point & c_wins;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q;

   // Abort on the TIMEOUT-th consecutive wait cycle of one transaction.
   assign abort = busy_st & ~m_ready & (tmo_q == TMO_LAST);

   // Wait-cycle counter: restarts with every grant, advances on each wait state.
   always_comb begin
      tmo_d = tmo_q;
      if (c_gnt | d_gnt) begin
         tmo_d = '0;
      end else if (busy_st & ~m_ready) begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   // Timeout state: the err pulse lines up with the aborted read's rvalid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= abort;
      end
   end

   assign err = err_q;
`else
   assign abort = 1'b0;
   assign err   = 1'b0;
`endif

   // Transaction FSM and memory request registers.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d   = state_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      if (d_gnt) begin
         state_d   = S_BUSY_D;
         m_req_d   = 1'b1;
         m_we_d    = d_we;
         m_addr_d  = d_addr;
         m_wdata_d = d_wdata;
      end else if (c_gnt) begin
         state_d   = S_BUSY_C;
         m_req_d   = 1'b1;
         m_we_d    = c_we;
         m_addr_d  = c_addr;
         m_wdata_d = c_wdata;
      end else if (arb_point | abort | ~busy_st) begin
         // Nothing granted at an arbitration point, a timeout abort, or an
         // unused state encoding: return to IDLE.
         state_d = S_IDLE;
         m_req_d = 1'b0;
      end
   end

   // Starvation counter: counts core grants that bypass a waiting debug request.
   always_comb begin
      starve_d = starve_q;
      if (arb_point) begin
         if (d_gnt | ~d_req) begin
            starve_d = '0;
         end else if (c_gnt && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
         end
      end
   end

   // Read return: route m_rdata to the owning port, or return the abort pattern.
   always_comb begin
      c_rvalid_d = 1'b0;
      d_rvalid_d = 1'b0;
      c_rdata_d  = c_rdata_q;
      d_rdata_d  = d_rdata_q;
      if (complete & ~m_we_q) begin
         if (state_q == S_BUSY_C) begin
            c_rvalid_d = 1'b1;
            c_rdata_d  = m_rdata;
         end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = m_rdata;
         end
      end else if (abort & ~m_we_q) begin
         if (state_q == S_BUSY_C) begin
            c_rvalid_d = 1'b1;
            c_rdata_d  = ABORT_DATA;
         end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = ABORT_DATA;
         end
      end
   end

   // State registers; reset drops any in-flight transaction without a response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         starve_q   <= '0;
         c_rvalid_q <= 1'b0;
         c_rdata_q  <= '0;
         d_rvalid_q <= 1'b0;
         d_rdata_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         m_req_q    <= m_req_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         starve_q   <= starve_d;
         c_rvalid_q <= c_rvalid_d;
         c_rdata_q  <= c_rdata_d;
         d_rvalid_q <= d_rvalid_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign m_req    = m_req_q;
   assign m_we     = m_we_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign busy     = m_req_q;
   assign c_rvalid = c_rvalid_q;
   assign c_rdata  = c_rdata_q;
   assign d_rvalid = d_rvalid_q;
   assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, self-checking bench for mem_arbiter.
// Inputs change 2 time units after the rising edge; outputs are sampled
// 1 unit later, well away from the next edge.
module tb_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        c_req, c_we, c_gnt, c_rvalid;
   logic [31:0] c_addr, c_wdata, c_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        m_req, m_we, m_ready;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        busy, err;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [9:0]  exp_d;

   mem_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .c_req    (c_req),
      .c_we     (c_we),
      .c_addr   (c_addr),
      .c_wdata  (c_wdata),
      .c_gnt    (c_gnt),
      .c_rvalid (c_rvalid),
      .c_rdata  (c_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_gnt    (d_gnt),
      .d_rvalid (d_rvalid),
      .d_rdata  (d_rdata),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_ready  (m_ready),
      .m_rdata  (m_rdata),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      reset   = 1'b0;
      c_req   = 1'b1;
      c_we    = 1'b0;
      c_addr  = 32'h40;
      c_wdata = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      m_ready = 1'b0;
      m_rdata = '0;
      #1 reset = 1'b1;
      #2;
      // Reset state, with a core request pending that must not be granted.
      check("rst_c_gnt", c_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_m_req", m_req, 0);
      check("rst_busy", busy, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_c_rvalid", c_rvalid, 0);
      check("rst_err", err, 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
      c_req = 1'b0;

      // Core read at 0x40, m_ready tied high.
      next_cycle();
      c_req   = 1'b1;
      c_we    = 1'b0;
      c_addr  = 32'h40;
      m_ready = 1'b1;
      m_rdata = 32'h1234_5678;
      #1;
      check("t1_c_gnt", c_gnt, 1);
      check("t1_d_gnt", d_gnt, 0);
      next_cycle();
      c_req = 1'b0;
      #1;
      check("t1_m_req", m_req, 1);
      check("t1_m_addr", m_addr, 32'h40);
      check("t1_m_we", m_we, 0);
      check("t1_rvalid_early", c_rvalid, 0);
      next_cycle();
      #1;
      check("t1_c_rvalid", c_rvalid, 1);
      check("t1_c_rdata", c_rdata, 32'h1234_5678);
      check("t1_m_req_drop", m_req, 0);
      next_cycle();
      #1;
      check("t1_rvalid_pulse", c_rvalid, 0);
      check("t1_rdata_hold", c_rdata, 32'h1234_5678);

      // Core write with 3 wait states.
      next_cycle();
      m_ready = 1'b0;
      c_req   = 1'b1;
      c_we    = 1'b1;
      c_addr  = 32'h80;
      c_wdata = 32'hCAFE_F00D;
      #1;
      check("t2_c_gnt", c_gnt, 1);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         c_req   = 1'b0;
         m_ready = (i == 3);
         #1;
         check($sformatf("t2_m_req%0d", i), m_req, 1);
         check($sformatf("t2_m_we%0d", i), m_we, 1);
         check($sformatf("t2_m_addr%0d", i), m_addr, 32'h80);
         check($sformatf("t2_m_wdata%0d", i), m_wdata, 32'hCAFE_F00D);
         check($sformatf("t2_busy%0d", i), busy, 1);
         check($sformatf("t2_rvalid%0d", i), c_rvalid, 0);
      end
      next_cycle();
      m_ready = 1'b0;
      c_we    = 1'b0;
      #1;
      check("t2_busy_drop", busy, 0);
      check("t2_no_rvalid", c_rvalid, 0);

      // Both ports request continuously: expect C,C,C,C,D,C,C,C,C,D.
      exp_d   = 10'b10_0001_0000;
      m_ready = 1'b1;
      m_rdata = 32'h5555_AAAA;
      c_addr  = 32'h1000;
      d_addr  = 32'h2000;
      next_cycle();
      c_req = 1'b1;
      d_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i != 0) next_cycle();
         #1;
         check($sformatf("t3_c_gnt%0d", i), c_gnt, !exp_d[i]);
         check($sformatf("t3_d_gnt%0d", i), d_gnt, exp_d[i]);
         check($sformatf("t3_excl%0d", i), c_gnt & d_gnt, 0);
         if (i > 0) check($sformatf("t3_m_addr%0d", i), m_addr, exp_d[i-1] ? 32'h2000 : 32'h1000);
         if (i > 1) begin
            check($sformatf("t3_c_rvalid%0d", i), c_rvalid, !exp_d[i-2]);
            check($sformatf("t3_d_rvalid%0d", i), d_rvalid, exp_d[i-2]);
         end
      end
      next_cycle();
      c_req = 1'b0;
      d_req = 1'b0;
      #1;
      check("t3_last_addr", m_addr, 32'h2000);
      next_cycle();
      #1;
      check("t3_last_d_rvalid", d_rvalid, 1);
      check("t3_last_d_rdata", d_rdata, 32'h5555_AAAA);
      check("t3_idle", m_req, 0);

      // Debug-only read at 0x100 from idle.
      next_cycle();
      m_rdata = 32'hA5A5_0100;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h100;
      #1;
      check("t4_d_gnt", d_gnt, 1);
      check("t4_c_gnt", c_gnt, 0);
      next_cycle();
      d_req = 1'b0;
      #1;
      check("t4_m_addr", m_addr, 32'h100);
      check("t4_m_req", m_req, 1);
      next_cycle();
      #1;
      check("t4_d_rvalid", d_rvalid, 1);
      check("t4_d_rdata", d_rdata, 32'hA5A5_0100);
      check("t4_c_rvalid", c_rvalid, 0);

      // Asynchronous reset in BUSY_C with m_ready low.
      next_cycle();
      m_ready = 1'b0;
      c_req   = 1'b1;
      c_addr  = 32'h200;
      #1;
      check("t5_c_gnt", c_gnt, 1);
      next_cycle();
      c_req = 1'b0;
      #1;
      check("t5_m_req_pre", m_req, 1);
      #1 reset = 1'b1;
      #1;
      check("t5_m_req_async", m_req, 0);
      check("t5_busy_async", busy, 0);
      c_req = 1'b1;
      #1;
      check("t5_gnt_in_reset", c_gnt, 0);
      c_req = 1'b0;
      next_cycle();
      reset   = 1'b0;
      m_ready = 1'b1;
      #1;
      check("t5_no_rvalid_a", c_rvalid, 0);
      check("t5_idle", m_req, 0);
      next_cycle();
      #1;
      check("t5_no_rvalid_b", c_rvalid, 0);
      next_cycle();
      c_req  = 1'b1;
      c_addr = 32'h300;
      #1;
      check("t5_regrant", c_gnt, 1);
      next_cycle();
      c_req = 1'b0;
      #1;
      check("t5_m_addr", m_addr, 32'h300);
      next_cycle();
      #1;
      check("t5_c_rvalid", c_rvalid, 1);
      check("t5_c_rdata", c_rdata, 32'hA5A5_0100);

`ifdef ARB_TIMEOUT_EN
      // Core read with m_ready stuck low: abort after 16 wait cycles.
      next_cycle();
      m_ready = 1'b0;
      c_req   = 1'b1;
      c_we    = 1'b0;
      c_addr  = 32'h400;
      #1;
      check("t6_c_gnt", c_gnt, 1);
      for (int i = 1; i <= 16; i++) begin
         next_cycle();
         c_req = 1'b0;
         #1;
         check($sformatf("t6_m_req%0d", i), m_req, 1);
         check($sformatf("t6_err%0d", i), err, 0);
         check($sformatf("t6_rvalid%0d", i), c_rvalid, 0);
      end
      next_cycle();
      #1;
      check("t6_abort_m_req", m_req, 0);
      check("t6_abort_rvalid", c_rvalid, 1);
      check("t6_abort_rdata", c_rdata, 32'hDEAD_BEEF);
      check("t6_abort_err", err, 1);
      next_cycle();
      #1;
      check("t6_err_pulse", err, 0);
      check("t6_rvalid_pulse", c_rvalid, 0);
`else
      check("t6_err_tied", err, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
